// File: rtl/timer_sched_pkg.sv
// Shared types and the round-robin pick helper for timer_sched.
package timer_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Widest requester vector the pick helper handles; callers zero-extend.
    localparam int RR_MAX = 32;

    // One-hot grant of the first valid requester after `last`, wrapping mod n.
    function automatic logic [RR_MAX-1:0] rr_pick(
        input logic [RR_MAX-1:0] valid,
        input int unsigned       last,
        input int unsigned       n
    );
        logic [RR_MAX-1:0] grant;
        logic              found;
        int unsigned       idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= RR_MAX; k++) begin
            idx = (last + k) % n;
            if (k <= n && !found && valid[idx[4:0]]) begin
                grant[idx[4:0]] = 1'b1;
                found           = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/timer_sched_timer.sv
// Prescaled countdown timer: one count step every 2^ps enabled cycles.
module timer #(
    parameter int TIMER_BITS  = 8,
    parameter int SCALER_BITS = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [TIMER_BITS-1:0]  init,
    input  logic [SCALER_BITS-1:0] ps,
    output logic                   done
);
    localparam int SCW = (1 << SCALER_BITS) - 1;

    logic [TIMER_BITS-1:0] r_count;
    logic [SCW-1:0]        r_scaler;
    logic [SCW-1:0]        w_mask;

    assign w_mask = ~({SCW{1'b1}} << ps);
    assign done   = (r_count == '0);

    // reset_n here is a gated load strobe from the scheduler, so it is sampled
    // synchronously: it preloads init and clears the scaler.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count  <= init;
            r_scaler <= '0;
        end else if (enable && r_count != '0) begin
            if (r_scaler == w_mask) begin
                r_scaler <= '0;
                r_count  <= r_count - 1'b1;
            end else begin
                r_scaler <= r_scaler + 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_sched.sv
// Round-robin scheduler sharing one prescaled countdown timer among NREQ requesters.
module timer_sched
    import timer_sched_pkg::*;
#(
    parameter int  NREQ        = 4,
    parameter int  TIMER_BITS  = 8,
    parameter int  SCALER_BITS = 2,
    localparam int IDW         = $clog2(NREQ)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*TIMER_BITS-1:0]    req_init,
    input  logic [NREQ*SCALER_BITS-1:0]   req_ps,
    input  logic [NREQ-1:0]               cancel,
    output logic [NREQ-1:0]               expire,
    output logic                          busy,
    output logic [IDW-1:0]                owner,
    output state_t                        dbg_state
);
    // Handshake: job i transfers on a rising edge where req_valid[i] & req_ready[i];
    // req_ready is only ever raised in IDLE and is one-hot.
    state_t                 r_state, w_state_next;
    logic [IDW-1:0]         r_owner, r_last, w_grant_idx;
    logic [TIMER_BITS-1:0]  r_init;
    logic [SCALER_BITS-1:0] r_ps;
    logic [NREQ-1:0]        r_expire, w_expire_next, w_grant;
    logic                   r_busy;
    logic [RR_MAX-1:0]      w_pick;
    logic                   w_accept, w_release, w_cancel_own;
    logic                   w_tmr_rst_n, w_tmr_en, w_tmr_done;

    assign w_pick       = rr_pick(RR_MAX'(req_valid), 32'(r_last), NREQ);
    assign w_cancel_own = cancel[r_owner];

    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) w_grant_idx = IDW'(i);
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_grant       = '0;
        w_accept      = 1'b0;
        w_release     = 1'b0;
        w_tmr_en      = 1'b0;
        w_expire_next = '0;
        case (r_state)
            IDLE: begin
                w_grant  = w_pick[NREQ-1:0];
                w_accept = |w_grant;
                if (w_accept) w_state_next = LOAD;
            end
            LOAD: begin
                w_state_next = w_cancel_own ? IDLE : RUN;
                w_release    = w_cancel_own;
            end
            RUN: begin
                w_tmr_en = 1'b1;
                // Cancel beats a coincident done: the job is dropped silently.
                if (w_cancel_own) begin
                    w_state_next = IDLE;
                    w_release    = 1'b1;
                end else if (w_tmr_done) begin
                    w_state_next           = DONE;
                    w_expire_next[r_owner] = 1'b1;
                end
            end
            DONE: begin
                w_state_next = IDLE;
                w_release    = 1'b1;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_owner  <= '0;
            r_last   <= IDW'(NREQ - 1);
            r_init   <= '0;
            r_ps     <= '0;
            r_expire <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_expire <= w_expire_next;
            r_busy   <= (w_state_next != IDLE);
            if (w_accept) begin
                r_owner <= w_grant_idx;
                r_init  <= req_init[w_grant_idx*TIMER_BITS +: TIMER_BITS];
                r_ps    <= req_ps[w_grant_idx*SCALER_BITS +: SCALER_BITS];
            end
            if (w_release) r_last <= r_owner;
        end
    end

    assign w_tmr_rst_n = reset_n & (r_state != LOAD);

    timer #(
        .TIMER_BITS  (TIMER_BITS),
        .SCALER_BITS (SCALER_BITS)
    ) u_timer (
        .clk     (clk),
        .reset_n (w_tmr_rst_n),
        .enable  (w_tmr_en),
        .init    (r_init),
        .ps      (r_ps),
        .done    (w_tmr_done)
    );

    assign req_ready = w_grant;
    assign expire    = r_expire;
    assign busy      = r_busy;
    assign owner     = r_owner;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_timer_sched.sv
// Self-checking bench for timer_sched: spec-constant vector table, hand sequences, random jobs.
module tb_timer_sched;
    import timer_sched_pkg::*;

    localparam int NREQ = 4;
    localparam int TB   = 8;
    localparam int SB   = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NREQ-1:0]  req_valid, req_ready, cancel, expire;
    logic [NREQ*TB-1:0] req_init;
    logic [NREQ*SB-1:0] req_ps;
    logic             busy;
    logic [1:0]       owner;
    state_t           dbg_state;

    logic [TB-1:0]    p_init [NREQ];
    logic [SB-1:0]    p_ps   [NREQ];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int m_last   = NREQ - 1;
    logic [NREQ-1:0] exp_q [$];

    typedef struct {
        int idx;
        int init;
        int ps;
        int cancel_at;
        int exp_cyc;
    } vec_t;
    vec_t tbl [7];

    timer_sched #(
        .NREQ        (NREQ),
        .TIMER_BITS  (TB),
        .SCALER_BITS (SB)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_init  (req_init),
        .req_ps    (req_ps),
        .cancel    (cancel),
        .expire    (expire),
        .busy      (busy),
        .owner     (owner),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_init[i*TB +: TB] = p_init[i];
            req_ps[i*SB +: SB]   = p_ps[i];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // First requester with a pending job after `last`, wrapping.
    function automatic int rr_model(input logic [NREQ-1:0] m, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (m[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        req_valid = '0;
        cancel    = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_expire", expire, 0);
        chk("rst_owner", owner, 0);
        chk("rst_ready", req_ready, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_last  = NREQ - 1;
        exp_q.delete();
    endtask

    // Entered at a negedge of an IDLE cycle with requests driven; that cycle is cycle 0.
    // noise: 0 none, 1 all non-owner cancel bits, 2 random non-owner cancel bits.
    task automatic run_job(input int win, input int cancel_at, input int exp_cyc,
                           input int noise, input string tag);
        logic [NREQ-1:0] oh;
        logic [NREQ-1:0] nz;
        int seen, busy_bad, end_c;
        oh = NREQ'(1) << win;
        #1;
        chk({tag, "_ready"}, req_ready, oh);
        if (exp_cyc > 0) exp_q.push_back(oh);
        @(negedge clk);
        req_valid[win] = 1'b0;
        chk({tag, "_owner"}, owner, win);
        chk({tag, "_load"}, dbg_state, LOAD);
        seen     = -1;
        busy_bad = 0;
        end_c    = (exp_cyc > 0) ? exp_cyc : cancel_at;
        for (int c = 1; c <= end_c; c++) begin
            if (c > 1) @(negedge clk);
            if (busy !== 1'b1) busy_bad++;
            if (expire !== '0) begin
                if (seen < 0) seen = c;
                if (exp_q.size() == 0) chk({tag, "_spurious_expire"}, expire, 0);
                else chk({tag, "_expire_vec"}, expire, exp_q.pop_front());
            end
            nz     = (noise == 1) ? ~oh : (noise == 2) ? (NREQ'($urandom) & ~oh) : '0;
            cancel = nz | ((c == cancel_at) ? oh : '0);
        end
        @(negedge clk);
        cancel = '0;
        if (expire !== '0) chk({tag, "_late_expire"}, expire, 0);
        chk({tag, "_busy_during"}, busy_bad, 0);
        chk({tag, "_expire_cyc"}, seen, (exp_cyc > 0) ? exp_cyc : -1);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_idle_after"}, dbg_state, IDLE);
        exp_q.delete();
        m_last = win;
    endtask

    // ---------------- test body ----------------
    initial begin
        int grants, prev, idx, n_exp, win, span, r, cancel_at, exp_cyc;
        logic [NREQ-1:0] pend, add;

        reset_n   = 1'b0;
        req_valid = '0;
        cancel    = '0;
        for (int i = 0; i < NREQ; i++) begin
            p_init[i] = '0;
            p_ps[i]   = '0;
        end

        // {idx, init, ps, cancel_at (-1 none), expected expire cycle (0 none)}
        tbl[0] = '{0, 5,   0, -1, 8};
        tbl[1] = '{1, 3,   2, -1, 15};
        tbl[2] = '{2, 0,   3, -1, 3};
        tbl[3] = '{3, 1,   0, -1, 4};
        tbl[4] = '{1, 255, 0, -1, 258};
        tbl[5] = '{2, 6,   0, 9,  9};
        tbl[6] = '{3, 0,   0, 2,  0};

        do_reset();
        for (int t = 0; t < 7; t++) begin
            p_init[tbl[t].idx] = TB'(tbl[t].init);
            p_ps[tbl[t].idx]   = SB'(tbl[t].ps);
            req_valid          = NREQ'(1) << tbl[t].idx;
            run_job(tbl[t].idx, tbl[t].cancel_at, tbl[t].exp_cyc, 0, $sformatf("tbl%0d", t));
        end

        // Round-robin with all requesters held valid.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            p_init[i] = 8'd1;
            p_ps[i]   = '0;
        end
        req_valid = '1;
        grants    = 0;
        prev      = -1;
        for (int t = 0; t < 60 && grants < 5; t++) begin
            #1;
            if (expire !== '0) begin
                if (exp_q.size() == 0) chk("rr_spurious_expire", expire, 0);
                else chk("rr_expire_vec", expire, exp_q.pop_front());
            end
            if (req_ready !== '0) begin
                idx = 0;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) idx = i;
                chk("rr_onehot", $countones(req_ready), 1);
                chk("rr_order", idx, grants % NREQ);
                if (prev >= 0) chk("rr_spacing", cyc - prev, 5);
                prev = cyc;
                exp_q.push_back(NREQ'(1) << idx);
                grants++;
            end
            @(negedge clk);
        end
        req_valid = '0;
        chk("rr_grants", grants, 5);
        repeat (8) begin
            @(negedge clk);
            if (expire !== '0) begin
                if (exp_q.size() == 0) chk("rr_spurious_expire", expire, 0);
                else chk("rr_expire_vec", expire, exp_q.pop_front());
            end
        end
        chk("rr_drain", exp_q.size(), 0);

        // Cancel by owner 2 in cycle 6 with cancel[1]/others ignored; then next grant goes to 3,
        // whose job is cancelled exactly in its done cycle.
        do_reset();
        p_init[2] = 8'd10;
        p_ps[2]   = '0;
        req_valid = 4'b0100;
        run_job(2, 6, 0, 1, "cancel2");
        p_init[3] = 8'd2;
        p_ps[3]   = '0;
        p_init[0] = 8'd1;
        req_valid = 4'b1001;
        #1;
        chk("cancel_next_grant", req_ready, 4'b1000);
        req_valid = 4'b1000;
        run_job(3, 4, 0, 0, "cancel_vs_done");

        // Asynchronous reset mid-RUN.
        do_reset();
        p_init[1] = 8'd20;
        p_ps[1]   = '0;
        req_valid = 4'b0010;
        #1;
        chk("areset_ready", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = '0;
        repeat (4) @(negedge clk);
        chk("areset_run", dbg_state, RUN);
        #2 reset_n = 1'b0;
        #1;
        chk("areset_busy", busy, 0);
        chk("areset_owner", owner, 0);
        chk("areset_state", dbg_state, IDLE);
        chk("areset_expire", expire, 0);
        @(negedge clk);
        reset_n   = 1'b1;
        req_valid = 4'b0011;
        #1;
        chk("areset_prio0", req_ready, 4'b0001);
        req_valid = '0;
        n_exp     = 0;
        repeat (40) begin
            @(negedge clk);
            if (expire !== '0) n_exp++;
        end
        chk("areset_no_expire", n_exp, 0);
        m_last = NREQ - 1;

        // Random jobs against the reference model.
        do_reset();
        pend = '0;
        for (int j = 0; j < 40; j++) begin
            add = NREQ'($urandom);
            if (pend == '0 && add == '0) add = NREQ'(1) << $urandom_range(0, NREQ - 1);
            for (int i = 0; i < NREQ; i++) begin
                if (add[i] && !pend[i]) begin
                    p_init[i] = TB'($urandom_range(0, 20));
                    p_ps[i]   = SB'($urandom_range(0, 3));
                end
            end
            pend      = pend | add;
            req_valid = pend;
            win       = rr_model(pend, m_last);
            span      = int'(p_init[win]) << p_ps[win];
            r         = $urandom_range(0, 3);
            cancel_at = (r == 0) ? $urandom_range(1, 2 + span) : (r == 1) ? 3 + span : -1;
            exp_cyc   = (cancel_at >= 1 && cancel_at <= 2 + span) ? 0 : 3 + span;
            run_job(win, cancel_at, exp_cyc, 2, $sformatf("rnd%0d", j));
            pend[win] = 1'b0;
        end
        req_valid = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
